// File: rtl/mips_dmem_resp.sv
// mips_dmem_resp: word-addressed data-memory responder with a fixed-latency request/response handshake.
module mips_dmem_resp #(
  parameter logic [29:0] BASE_WADDR = 30'h04000000,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_data_in,
  input  logic [3:0]  mem_write_en,
  output logic        mem_busy,
  output logic        mem_valid,
  output logic [31:0] mem_data_out,
  output logic        mem_excpt
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [29:0] addr, a_sel, off;
  logic [31:0] din, d_sel, merged;
  logic [3:0] we, w_sel;
  logic in_range;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH] = '{default: '0};
  // With LATENCY=1 the response is built on the accepting edge, before the request is captured.
  assign a_sel = state == IDLE ? mem_addr : addr;
  assign d_sel = state == IDLE ? mem_data_in : din;
  assign w_sel = state == IDLE ? mem_write_en : we;
  assign off = a_sel - BASE_WADDR;
  assign in_range = a_sel >= BASE_WADDR && off < 30'(DEPTH);
  assign idx = off[AW-1:0];
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i+:8] = w_sel[i] ? d_sel[8*i+:8] : mem[idx][8*i+:8];
  end
  assign mem_busy = state != IDLE;
  assign mem_valid = state == DONE;
  assign mem_excpt = state == DONE && !in_range;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (mem_req ? (LATENCY == 1 ? DONE : WAIT) : IDLE) :
              state == WAIT ? (cnt == 4'd0 ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
      mem_data_out <= 32'd0;
    end else begin
      if (state == IDLE && mem_req) begin
        addr <= mem_addr;
        din <= mem_data_in;
        we <= mem_write_en;
        cnt <= 4'(LATENCY - 2);
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state_n == DONE && state != DONE) mem_data_out <= in_range ? merged : 32'd0;
    end
  end
  // The store commits as DONE ends, so a reset during DONE still discards it.
  always_ff @(posedge clk) begin
    if (!rst && state == DONE && we != 4'd0 && in_range) mem[idx] <= mem_data_out;
  end
endmodule

// File: tb/tb_mips_dmem_resp.sv
// tb_mips_dmem_resp: directed checks of the data-memory responder at LATENCY=2 and LATENCY=3.
module tb_mips_dmem_resp;
  localparam logic [29:0] B = 30'h04000000;
  localparam int D = 1024;
  logic clk = 0, rst = 0;
  logic req, req3;
  logic [29:0] addr;
  logic [31:0] din;
  logic [3:0] we;
  logic busy, valid, excpt, busy3, valid3, excpt3;
  logic [31:0] dout, dout3;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  mips_dmem_resp #(.BASE_WADDR(B), .DEPTH(D), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .mem_req(req), .mem_addr(addr), .mem_data_in(din),
    .mem_write_en(we), .mem_busy(busy), .mem_valid(valid), .mem_data_out(dout), .mem_excpt(excpt));

  mips_dmem_resp #(.BASE_WADDR(B), .DEPTH(D), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .mem_req(req3), .mem_addr(B), .mem_data_in(32'd0),
    .mem_write_en(4'd0), .mem_busy(busy3), .mem_valid(valid3), .mem_data_out(dout3), .mem_excpt(excpt3));

  task automatic issue(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w,
                       output logic [31:0] rd, output logic ex, output int lat);
    @(negedge clk);
    req = 1; addr = a; din = d; we = w;
    @(posedge clk);
    #1 req = 0;
    lat = 99; rd = 'x; ex = 'x;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (valid) begin
        lat = k; rd = dout; ex = excpt;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1; req = 1; addr = B; din = 32'hFFFFFFFF; we = 4'hF;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (excpt !== 1'b0) begin n_fail++; $display("FAIL reset_excpt got %b want 0", excpt); end
    n_checks++; if (dout !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", dout); end
    rst = 0; req = 0;
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic ex; int lat;
    issue(B + 5, 32'hDEADBEEF, 4'hF, rd, ex, lat);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL store_latency got %0d want 2", lat); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_data got %h want deadbeef", rd); end
    n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL store_excpt got %b want 0", ex); end
    issue(B + 5, 32'h0, 4'h0, rd, ex, lat);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL load_latency got %0d want 2", lat); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_data got %h want deadbeef", rd); end
    n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL load_excpt got %b want 0", ex); end
  endtask

  task automatic test_byte_store;
    logic [31:0] rd; logic ex; int lat;
    issue(B + 5, 32'h0000AA00, 4'b0010, rd, ex, lat);
    n_checks++; if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL byte_store_data got %h want deadaaef", rd); end
    issue(B + 5, 32'hFFFFFFFF, 4'h0, rd, ex, lat);
    n_checks++; if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL byte_load_data got %h want deadaaef", rd); end
  endtask

  task automatic test_range;
    logic [31:0] rd; logic ex; int lat;
    issue(B + D - 1, 32'h0BADF00D, 4'hF, rd, ex, lat);
    n_checks++; if (rd !== 32'h0BADF00D || ex !== 1'b0) begin n_fail++; $display("FAIL last_word_store got %h/%b want 0badf00d/0", rd, ex); end
    issue(B + D, 32'h0, 4'h0, rd, ex, lat);
    n_checks++; if (lat != 2 || ex !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL load_above lat %0d excpt %b data %h want 2/1/0", lat, ex, rd); end
    issue(B - 1, 32'h0, 4'h0, rd, ex, lat);
    n_checks++; if (lat != 2 || ex !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL load_below lat %0d excpt %b data %h want 2/1/0", lat, ex, rd); end
    issue(B + D, 32'hFFFFFFFF, 4'hF, rd, ex, lat);
    n_checks++; if (ex !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL store_above excpt %b data %h want 1/0", ex, rd); end
    issue(B + D - 1, 32'h0, 4'h0, rd, ex, lat);
    n_checks++; if (rd !== 32'h0BADF00D || ex !== 1'b0) begin n_fail++; $display("FAIL last_word_kept got %h/%b want 0badf00d/0", rd, ex); end
    repeat (3) @(negedge clk);
    n_checks++; if (dout !== 32'h0BADF00D) begin n_fail++; $display("FAIL data_hold got %h want 0badf00d", dout); end
    n_checks++; if (valid !== 1'b0 || excpt !== 1'b0) begin n_fail++; $display("FAIL idle_strobes valid %b excpt %b want 0/0", valid, excpt); end
  endtask

  task automatic test_back_to_back;
    int busy_cnt = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      busy_cnt += int'(busy3);
      n_checks++; if (busy3 !== ((i % 4) != 0)) begin n_fail++; $display("FAIL held_busy cycle %0d got %b want %b", i, busy3, (i % 4) != 0); end
      n_checks++; if (valid3 !== ((i % 4) == 3)) begin n_fail++; $display("FAIL held_valid cycle %0d got %b want %b", i, valid3, (i % 4) == 3); end
      req3 = 1;
    end
    req3 = 0;
    n_checks++; if (busy_cnt != 12) begin n_fail++; $display("FAIL held_busy_total got %0d want 12", busy_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic ex; int lat; int seen = 0;
    @(negedge clk);
    req = 1; addr = B + 5; din = 32'h12345678; we = 4'hF;
    @(posedge clk);
    #1 req = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen += int'(valid);
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_valid got %0d pulses want 0", seen); end
    issue(B + 5, 32'h0, 4'h0, rd, ex, lat);
    n_checks++; if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL abort_load got %h want deadaaef", rd); end
  endtask

  initial begin
    req = 0; req3 = 0; addr = '0; din = '0; we = '0;
    test_reset();
    test_store_load();
    test_byte_store();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
